// File: rtl/regfile.sv
// regfile: 32 x width register file, two combinational read ports, one write port, XZR at X31
module regfile #(
  parameter int width = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       read_reg1,
  input  logic [4:0]       read_reg2,
  input  logic [4:0]       write_reg,
  input  logic [width-1:0] write_data,
  input  logic             reg_write,
  output logic [width-1:0] read_data1,
  output logic [width-1:0] read_data2
);
  logic [width-1:0] r_x [0:30];
  logic [width-1:0] w_view [0:31];
  logic [31:0]      w_dec;
  logic             w_byp;
  assign w_dec = reg_write ? (32'd1 << write_reg) : 32'd0;
  assign w_byp = reg_write && !reset && (write_reg != 5'd31);
  // X0-X30 storage; decoder output 31 has no register behind it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 31; i++) r_x[i] <= '0;
    end else begin
      for (int i = 0; i < 31; i++) if (w_dec[i]) r_x[i] <= write_data;
    end
  end
  // Read view of all 32 addresses, X31 reads as zero
  always_comb begin
    for (int i = 0; i < 31; i++) w_view[i] = r_x[i];
    w_view[31] = '0;
  end
  assign read_data1 = (w_byp && read_reg1 == write_reg) ? write_data : w_view[read_reg1];
  assign read_data2 = (w_byp && read_reg2 == write_reg) ? write_data : w_view[read_reg2];
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: vector table, corner sequences and randomized model check for regfile
module tb_regfile;
  logic        clk = 0, reset = 0, reg_write = 0;
  logic [4:0]  read_reg1 = 0, read_reg2 = 0, write_reg = 0;
  logic [63:0] write_data = 0, read_data1, read_data2;
  int checks = 0, passed = 0;
  logic [63:0] m [0:31];

  typedef struct {
    logic rw; logic [4:0] wr; logic [63:0] wd;
    logic [4:0] r1, r2; logic [63:0] e1, e2;
  } vec_t;
  vec_t tv [11];

  regfile #(.width(64)) dut (
    .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  function automatic logic [63:0] ref_rd(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (reset) return 64'd0;
    if (reg_write && write_reg == a) return write_data;
    return m[a];
  endfunction

  task automatic drive(input logic rw, input logic [4:0] wr, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    reg_write = rw; write_reg = wr; write_data = wd; read_reg1 = r1; read_reg2 = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reg_write && !reset && write_reg != 5'd31) m[write_reg] = write_data;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 64'd0;
    #1 reset = 1;
    #1 reset = 0;
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 5'(a), 5'(31 - a));
      chk($sformatf("reset_rd1[%0d]", a), read_data1, 64'd0);
      chk($sformatf("reset_rd2[%0d]", 31 - a), read_data2, 64'd0);
    end
    @(negedge clk);

    for (int k = 0; k < 31; k++) begin
      drive(1, 5'(k), 64'h1000 + 64'(k), 5'(k), 5'd31);
      chk($sformatf("sweep_bypass[%0d]", k), read_data1, 64'h1000 + 64'(k));
      tick();
    end
    for (int k = 0; k < 31; k++) begin
      drive(0, 0, 0, 5'(k), 5'(30 - k));
      chk($sformatf("sweep_rd1[%0d]", k), read_data1, 64'h1000 + 64'(k));
      chk($sformatf("sweep_rd2[%0d]", 30 - k), read_data2, 64'h1000 + 64'(30 - k));
    end

    tv[0]  = '{1'b1, 5'd31, 64'hDEADBEEF, 5'd31, 5'd31, 64'd0,    64'd0};
    tv[1]  = '{1'b0, 5'd0,  64'd0,        5'd0,  5'd30, 64'h1000, 64'h101E};
    tv[2]  = '{1'b1, 5'd5,  64'h5,        5'd5,  5'd4,  64'h5,    64'h1004};
    tv[3]  = '{1'b0, 5'd5,  64'hFFFF,     5'd5,  5'd6,  64'h5,    64'h1006};
    tv[4]  = '{1'b0, 5'd5,  64'hFFFF,     5'd5,  5'd6,  64'h5,    64'h1006};
    tv[5]  = '{1'b0, 5'd5,  64'hFFFF,     5'd5,  5'd6,  64'h5,    64'h1006};
    tv[6]  = '{1'b1, 5'd7,  64'h7,        5'd7,  5'd7,  64'h7,    64'h7};
    tv[7]  = '{1'b1, 5'd7,  64'hABCD,     5'd7,  5'd7,  64'hABCD, 64'hABCD};
    tv[8]  = '{1'b0, 5'd0,  64'd0,        5'd7,  5'd8,  64'hABCD, 64'h1008};
    tv[9]  = '{1'b1, 5'd7,  64'h1234,     5'd7,  5'd8,  64'h1234, 64'h1008};
    tv[10] = '{1'b0, 5'd0,  64'd0,        5'd7,  5'd31, 64'h1234, 64'd0};
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].rw, tv[i].wr, tv[i].wd, tv[i].r1, tv[i].r2);
      chk($sformatf("vec%0d_rd1", i), read_data1, tv[i].e1);
      chk($sformatf("vec%0d_rd2", i), read_data2, tv[i].e2);
      tick();
    end
    for (int k = 0; k < 31; k++) begin
      drive(0, 0, 0, 5'(k), 5'(k));
      chk($sformatf("after_vec[%0d]", k), read_data1,
          k == 5 ? 64'h5 : k == 7 ? 64'h1234 : 64'h1000 + 64'(k));
    end

    for (int n = 0; n < 300; n++) begin
      logic [4:0] wr;
      wr = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
      drive($urandom_range(0, 3) != 0, wr, {$urandom, $urandom},
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom), 5'($urandom));
      chk($sformatf("rand%0d_rd1", n), read_data1, ref_rd(read_reg1));
      chk($sformatf("rand%0d_rd2", n), read_data2, ref_rd(read_reg2));
      tick();
    end

    for (int k = 0; k < 31; k++) begin
      drive(1, 5'(k), 64'h5000 + 64'(k), 5'd31, 5'd31);
      tick();
    end
    drive(1, 5'd3, 64'h99, 5'd3, 5'd10);
    chk("pre_reset_bypass", read_data1, 64'h99);
    chk("pre_reset_x10", read_data2, 64'h500A);
    #1 reset = 1;
    for (int i = 0; i < 32; i++) m[i] = 64'd0;
    #1;
    chk("async_reset_rd1", read_data1, 64'd0);
    chk("async_reset_rd2", read_data2, 64'd0);
    tick();
    reset = 0;
    for (int k = 0; k < 31; k++) begin
      drive(0, 0, 0, 5'(k), 5'(30 - k));
      chk($sformatf("post_reset_rd1[%0d]", k), read_data1, 64'd0);
      chk($sformatf("post_reset_rd2[%0d]", 30 - k), read_data2, 64'd0);
    end
    drive(1, 5'd3, 64'h33, 5'd4, 5'd4);
    tick();
    drive(0, 0, 0, 5'd3, 5'd4);
    chk("x3_after_reset_write", read_data1, 64'h33);
    chk("x4_after_reset", read_data2, 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/regfile.md
# regfile

Architectural register file for the ARM datapath: 32 entries of `width` bits, two combinational read ports and one synchronous write port, with X31 (XZR) hard-wired to zero. It is built from 31 enabled storage registers with a 5:32 write decoder and two 32:1 read multiplexers. It sits between the decode stage, which supplies read addresses, and write-back, which supplies write address and data. A write-to-read bypass lets a write-back value reach a same-cycle decode read.

## Interface
- `width`, default 64: bits per register and per data port.
- `clk`  input  1  rising-edge clock for all storage.
- `reset`  input  1  asynchronous, active-high; clears every register.
- `read_reg1`  input  5  address for read port 1.
- `read_reg2`  input  5  address for read port 2.
- `write_reg`  input  5  destination address.
- `write_data`  input  `width`  data to write.
- `reg_write`  input  1  write enable.
- `read_data1`  output  `width`  contents of `read_reg1`.
- `read_data2`  output  `width`  contents of `read_reg2`.

## Operation
- Storage: X0–X30 are `width`-bit flip-flop registers, each with an enable. X31 has no storage. Reads of X31 always return 0.
- Write decode: a 5:32 decoder is gated by `reg_write`. Its output k drives the enable of Xk. Output 31 is left unconnected.
- Write: on the rising `clk` edge with `reg_write`=1 and `write_reg`≠31, `write_data` is captured into X[`write_reg`]. Every other register holds its value.
- Write to X31: ignored. No state changes.
- `reg_write`=0: no register changes, regardless of `write_reg` and `write_data`.
- Read: `read_dataN` = X[`read_regN`], combinationally. It is 0 when `read_regN`=31. Both ports are fully independent and may address the same register.
- Bypass: if `reg_write`=1, `write_reg`≠31 and `read_regN`=`write_reg`, then `read_dataN` = `write_data` in the same cycle, before the edge. This applies to each port independently, so both ports can bypass at once.
- Reset: while `reset`=1, X0–X30 are forced to 0 immediately, without waiting for a clock edge. Writes and bypass are suppressed, so both `read_data` outputs are 0.
- Reset values: X0–X30 are 0, and `read_data1` = `read_data2` = 0.

## Timing
- Read latency: 0 cycles (combinational from address or storage to output).
- Write latency: 1 edge. A value written at edge n is visible through storage after edge n. Through bypass it is visible during the cycle leading up to edge n.
- Simultaneous read and write of the same register: the read returns the new data (bypass), never the stale data.
- Reset mid-operation:
  - Asserting `reset` between edges clears all registers at once.
  - An edge that occurs while `reset`=1 writes nothing.
  - The first write after deassertion takes effect at the first rising edge with `reset`=0.
- Address or data changes between edges have no effect on storage. Only the values present at the rising edge matter.
- Combinational path for timing closure: `write_reg`/`read_reg` compare plus bypass mux plus 32:1 mux. This must fit within the decode-stage budget.

## Test plan
- Reset and readback:
  - Stimulus: pulse `reset` with no clock edge, then read all 32 addresses on both ports.
  - Required: every read is 0.
- Write/read sweep:
  - Stimulus: for k=0..30, write `64'h1000+k` at one edge each. Then read port1 = k and port2 = 30−k.
  - Required: port1 = `h1000+k`, port2 = `h1000+30−k`.
- XZR behaviour:
  - Stimulus: write `64'hDEADBEEF` to address 31, then read 31 on both ports.
  - Required: both reads return 0, including in the write cycle itself (no bypass).
  - Required: X0–X30 are unchanged.
- Write enable off:
  - Stimulus: X5 = `h5`. Drive `reg_write`=0, `write_reg`=5, `write_data`=`hFFFF` for 3 edges.
  - Required: `read_data1` at address 5 stays `h5`.
- Bypass:
  - Stimulus: X7 = `h7`. Drive `reg_write`=1, `write_reg`=7, `write_data`=`hABCD`, with both read addresses = 7.
  - Required: both outputs read `hABCD` before the edge and after it.
  - Required: with `read_reg2`=8 in the same cycle, port 2 shows X8 unaffected.
- Asynchronous reset mid-operation:
  - Stimulus: fill X0–X30 with nonzero values. Assert `reset` halfway between edges while `reg_write`=1, `write_reg`=3.
  - Required: all reads go to 0 immediately, and X3 stays 0 across the edge that occurs during reset.
  - Required: after deassertion, a write of `h33` to X3 appears after the next edge.
